// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding is fixed so waveforms read the same across builds.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter never drops below one bit, even for tiny widths.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake between a controller (master) and the serial subtractor (slave).
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/full_sub_cell.sv
// Combinational full subtractor built from two half subtractors and an OR of their borrows.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_sub u_hs_xy (
    .x(x),
    .y(y),
    .d(d1),
    .b(b1)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_sub u_hs_bin (
    .x(d1),
    .y(bin),
    .d(d),
    .b(b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/half_sub.sv
// Combinational half subtractor: d = x - y, b = borrow.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  assign d = x ^ y;
  assign b = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
// Results are registered and only change on the completion edge.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             busy_r;
  logic             done_r;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] rr_next;
  logic             last_bit;

  full_sub_cell u_cell (
    .x(ra[0]),
    .y(rb[0]),
    .bin(br),
    .d(d),
    .bout(br_next)
  );

  assign rr_next  = {d, rr[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // DONE accepts a new start exactly like IDLE so back-to-back operations lose no cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ra       <= '0;
      rb       <= '0;
      rr       <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            ra     <= bus.a;
            rb     <= bus.b;
            rr     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          rr  <= rr_next;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            diff_r   <= rr_next;
            borrow_r <= br_next;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table plus hand sequences,
// with a scoreboard queue popped on every done pulse.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  int checkCount = 0;
  int passCount  = 0;

  logic [W:0]   expQ[$];
  logic [W:0]   popped;
  logic [W-1:0] prevDiff;
  logic         prevRst = 1'b1;

  vec_t vecs[6];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer plus handshake invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy || bus.done)
        checkOutput("busy_done_exclusive", 32'(bus.busy & bus.done), 32'd0);
      if (bus.done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("diff", 32'(bus.diff), 32'(popped[W-1:0]));
          checkOutput("borrow_out", 32'(bus.borrow_out), 32'(popped[W]));
        end
      end else if (!prevRst) begin
        checkOutput("diff_hold", 32'(bus.diff), 32'(prevDiff));
      end
    end
    prevDiff = bus.diff;
    prevRst  = rst;
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W:0] exp, input bit midStart);
    int n;
    int busyCount;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    expQ.push_back(exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n         = 0;
    busyCount = 0;
    while (n < 4 * W) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      if (bus.busy) busyCount++;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      if (midStart) bus.start = (n == 3);
    end
    bus.start = 1'b0;
    checkOutput("latency", 32'(n - 1), 32'(W));
    checkOutput("busy_cycles", 32'(busyCount), 32'(W));
  endtask

  initial begin
    int n;
    int dones;
    int lastDone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, bout: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, bout: 1'b1};
    vecs[2] = '{a: 8'hA5, b: 8'hA5, diff: 8'h00, bout: 1'b0};
    vecs[3] = '{a: 8'h00, b: 8'hFF, diff: 8'h01, bout: 1'b1};
    vecs[4] = '{a: 8'hFF, b: 8'h00, diff: 8'hFF, bout: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bout: 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_diff", 32'(bus.diff), 32'd0);
    checkOutput("reset_borrow", 32'(bus.borrow_out), 32'd0);

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].a, vecs[i].b, {vecs[i].bout, vecs[i].diff}, 1'b0);

    // Random operands against an independent 9-bit arithmetic model.
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      applyStimulus(ra, rb, {1'b0, ra} - {1'b0, rb}, 1'b0);
    end

    // A start raised mid-operation with other operands must be ignored.
    applyStimulus(8'h20, 8'h07, {1'b0, 8'h19}, 1'b1);

    // Start held high: a result every WIDTH+1 cycles.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    repeat (3) expQ.push_back({1'b0, 8'h0F});
    n        = 0;
    dones    = 0;
    lastDone = 0;
    while (dones < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        dones++;
        if (dones > 1) checkOutput("b2b_period", 32'(n - lastDone), 32'(W + 1));
        lastDone = n;
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b_count", 32'(dones), 32'd3);

    // Leave a nonzero result with borrow set, then abort an operation with reset.
    applyStimulus(8'h03, 8'h05, {1'b1, 8'hFE}, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 8'h77;
    bus.b     = 8'h11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_diff", 32'(bus.diff), 32'd0);
    checkOutput("abort_borrow", 32'(bus.borrow_out), 32'd0);
    dones = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checkOutput("abort_no_done", 32'(dones), 32'd0);

    applyStimulus(8'h09, 8'h04, {1'b0, 8'h05}, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
